// File: rtl/aia_pkg.sv
// rtl/aia_pkg.sv - shared AIA types and constants for the APLIC MSI path
package aia_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BACKOFF
    } msi_state_e;

    localparam logic [31:0] FILE_STRIDE    = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_BASE_M = 32'h2400_0000;
    localparam logic [31:0] DEFAULT_BASE_S = 32'h2800_0000;

    // File 0 is the M file; a hart's S and VS files sit contiguously in the S region.
    function automatic logic [31:0] msi_addr(input logic [31:0] base_m,
                                             input logic [31:0] base_s,
                                             input logic [31:0] hart,
                                             input logic [31:0] file,
                                             input logic [31:0] files_per_hart);
        if (file == 32'd0)
            return base_m + hart * FILE_STRIDE;
        return base_s + (hart * files_per_hart + file - 32'd1) * FILE_STRIDE;
    endfunction

endpackage

// File: rtl/aplic_msi_fifo.sv
// rtl/aplic_msi_fifo.sv - power-of-two message buffer with occupancy count
module aplic_msi_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/aplic_msi_dispatcher.sv
// rtl/aplic_msi_dispatcher.sv - round-robin MSI request dispatcher with buffered, retried IMSIC writes
module aplic_msi_dispatcher
    import aia_pkg::*;
#(
    parameter int          NR_CH       = 4,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          NR_HARTS    = 1,
    parameter int          NR_VS_FILES = 1,
    parameter int          EIID_W      = 11,
    parameter int          MAX_RETRY   = 3,
    parameter logic [31:0] BASE_M      = DEFAULT_BASE_M,
    parameter logic [31:0] BASE_S      = DEFAULT_BASE_S,
    localparam int         HART_W      = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1,
    localparam int         FILE_W      = $clog2(NR_VS_FILES + 2)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NR_CH-1:0]         i_ch_valid,
    output logic [NR_CH-1:0]         o_ch_ready,
    input  logic [NR_CH*HART_W-1:0]  i_ch_hart,
    input  logic [NR_CH*FILE_W-1:0]  i_ch_file,
    input  logic [NR_CH*EIID_W-1:0]  i_ch_eiid,
    output logic [31:0]              o_req_addr,
    output logic [31:0]              o_req_wdata,
    output logic                     o_req_valid,
    input  logic                     i_req_ready,
    input  logic                     i_req_error,
    output logic                     o_drop,
    output logic [15:0]              o_drop_cnt,
    output logic                     o_busy
);

    localparam int CH_W    = (NR_CH > 1) ? $clog2(NR_CH) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int ENTRY_W = 32 + EIID_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    msi_state_e          state;
    logic [CH_W-1:0]     rr_ptr;
    logic [RETRY_W-1:0]  retry;

    logic                grant_any;
    logic [CH_W-1:0]     grant_idx;
    logic [HART_W-1:0]   sel_hart;
    logic [FILE_W-1:0]   sel_file;
    logic [EIID_W-1:0]   sel_eiid;
    logic                accept;
    logic                bad_req;
    logic                push;
    logic                chan_drop;
    logic                pop;
    logic                bus_drop;
    logic                retry_exhausted;
    logic [16:0]         drop_sum;

    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    // First valid channel at or after the round-robin pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NR_CH; k++) begin
            for (int c = 0; c < NR_CH; c++) begin
                if (!grant_any && c == (int'(rr_ptr) + k) % NR_CH && i_ch_valid[c]) begin
                    grant_any = 1'b1;
                    grant_idx = CH_W'(c);
                end
            end
        end
    end

    assign accept = grant_any && !fifo_full && !i_rst;

    always_comb begin
        sel_hart   = '0;
        sel_file   = '0;
        sel_eiid   = '0;
        o_ch_ready = '0;
        for (int c = 0; c < NR_CH; c++) begin
            if (grant_idx == CH_W'(c)) begin
                sel_hart      = i_ch_hart[c*HART_W +: HART_W];
                sel_file      = i_ch_file[c*FILE_W +: FILE_W];
                sel_eiid      = i_ch_eiid[c*EIID_W +: EIID_W];
                o_ch_ready[c] = accept;
            end
        end
    end

    assign bad_req   = (sel_eiid == '0)
                    || (32'(sel_file) > 32'(NR_VS_FILES + 1))
                    || (32'(sel_hart) >= 32'(NR_HARTS));
    assign push      = accept && !bad_req;
    assign chan_drop = accept && bad_req;

    assign push_entry = {msi_addr(BASE_M, BASE_S, 32'(sel_hart), 32'(sel_file),
                                  32'(NR_VS_FILES + 1)), sel_eiid};

    assign retry_exhausted = (retry == RETRY_W'(MAX_RETRY));
    assign pop      = (state == ST_ISSUE) && i_req_ready && (!i_req_error || retry_exhausted);
    assign bus_drop = (state == ST_ISSUE) && i_req_ready && i_req_error && retry_exhausted;
    assign drop_sum = 17'(o_drop_cnt) + 17'(chan_drop) + 17'(bus_drop);

    aplic_msi_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            retry      <= '0;
            rr_ptr     <= '0;
            o_drop     <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            o_drop     <= chan_drop || bus_drop;
            o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (accept)
                rr_ptr <= CH_W'((int'(grant_idx) + 1) % NR_CH);
            case (state)
                ST_IDLE: begin
                    // Entering on the push itself gives a one-cycle accept-to-issue latency.
                    if (!fifo_empty || push)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (i_req_ready) begin
                        if (i_req_error && !retry_exhausted) begin
                            retry <= retry + RETRY_W'(1);
                            state <= ST_BACKOFF;
                        end else begin
                            retry <= '0;
                            state <= (fifo_count > CNT_W'(1) || push) ? ST_ISSUE : ST_IDLE;
                        end
                    end
                end
                ST_BACKOFF: state <= ST_ISSUE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_valid = (state == ST_ISSUE);
    assign o_req_addr  = o_req_valid ? head_entry[ENTRY_W-1:EIID_W] : 32'd0;
    assign o_req_wdata = o_req_valid ? 32'(head_entry[EIID_W-1:0]) : 32'd0;
    assign o_busy      = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_aplic_msi_dispatcher.sv
// tb/tb_aplic_msi_dispatcher.sv - directed self-checking bench for aplic_msi_dispatcher
module tb_aplic_msi_dispatcher;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_ch_valid = '0;
    logic [3:0]  o_ch_ready;
    logic [7:0]  i_ch_hart = '0;
    logic [7:0]  i_ch_file = '0;
    logic [43:0] i_ch_eiid = '0;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wdata;
    logic        o_req_valid;
    logic        i_req_ready = 1'b0;
    logic        i_req_error = 1'b0;
    logic        o_drop;
    logic [15:0] o_drop_cnt;
    logic        o_busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    always #5 i_clk = ~i_clk;

    aplic_msi_dispatcher #(
        .NR_CH(4), .FIFO_DEPTH(4), .NR_HARTS(3), .NR_VS_FILES(1), .EIID_W(11),
        .MAX_RETRY(3), .BASE_M(32'h2400_0000), .BASE_S(32'h2800_0000)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ch_valid(i_ch_valid), .o_ch_ready(o_ch_ready),
        .i_ch_hart(i_ch_hart), .i_ch_file(i_ch_file), .i_ch_eiid(i_ch_eiid),
        .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata), .o_req_valid(o_req_valid),
        .i_req_ready(i_req_ready), .i_req_error(i_req_error),
        .o_drop(o_drop), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic v, input logic [1:0] hart,
                          input logic [1:0] file, input logic [10:0] eiid);
        i_ch_valid[c]         = v;
        i_ch_hart[c*2 +: 2]   = hart;
        i_ch_file[c*2 +: 2]   = file;
        i_ch_eiid[c*11 +: 11] = eiid;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        set_ch(0, 1'b1, 2'd0, 2'd0, 11'd5);
        #1;
        vec_cnt++; if (o_ch_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_ready got %b exp 0000", o_ch_ready); end
        vec_cnt++; if (o_req_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b exp 0", o_req_valid); end
        vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        vec_cnt++; if (o_drop !== 1'b0) begin err_cnt++; $display("FAIL reset_drop got %b exp 0", o_drop); end
        vec_cnt++; if (o_drop_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_drop_cnt got %0d exp 0", o_drop_cnt); end
        vec_cnt++; if (o_req_addr !== 32'd0) begin err_cnt++; $display("FAIL reset_addr got %h exp 0", o_req_addr); end
        tick();
        set_ch(0, 1'b0, 2'd0, 2'd0, 11'd0);
        i_rst = 1'b0;
    endtask

    task automatic test_single();
        tick();
        set_ch(0, 1'b1, 2'd0, 2'd0, 11'd5);
        #1;
        vec_cnt++; if (o_ch_ready !== 4'b0001) begin err_cnt++; $display("FAIL single_ready got %b exp 0001", o_ch_ready); end
        tick();
        set_ch(0, 1'b0, 2'd0, 2'd0, 11'd0);
        #1;
        vec_cnt++; if (o_req_valid !== 1'b1) begin err_cnt++; $display("FAIL single_latency got %b exp 1", o_req_valid); end
        vec_cnt++; if (o_req_addr !== 32'h2400_0000) begin err_cnt++; $display("FAIL single_addr got %h exp 24000000", o_req_addr); end
        vec_cnt++; if (o_req_wdata !== 32'd5) begin err_cnt++; $display("FAIL single_wdata got %h exp 5", o_req_wdata); end
        tick();
        #1;
        vec_cnt++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h2400_0000) begin err_cnt++; $display("FAIL single_hold got %b/%h exp 1/24000000", o_req_valid, o_req_addr); end
        i_req_ready = 1'b1;
        tick();
        i_req_ready = 1'b0;
        #1;
        vec_cnt++; if (o_req_valid !== 1'b0) begin err_cnt++; $display("FAIL single_done_valid got %b exp 0", o_req_valid); end
        vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy got %b exp 0", o_busy); end
    endtask

    task automatic test_vs_targets();
        int          ch[3]   = '{1, 2, 3};
        logic [1:0]  hart[3] = '{2'd1, 2'd2, 2'd2};
        logic [1:0]  file[3] = '{2'd2, 2'd1, 2'd0};
        logic [10:0] eiid[3] = '{11'd7, 11'd9, 11'h7ff};
        logic [31:0] addr[3] = '{32'h2800_3000, 32'h2800_4000, 32'h2400_2000};
        for (int v = 0; v < 3; v++) begin
            tick();
            set_ch(ch[v], 1'b1, hart[v], file[v], eiid[v]);
            #1;
            vec_cnt++; if (o_ch_ready !== 4'(1 << ch[v])) begin err_cnt++; $display("FAIL vs_ready[%0d] got %b exp %b", v, o_ch_ready, 4'(1 << ch[v])); end
            tick();
            set_ch(ch[v], 1'b0, 2'd0, 2'd0, 11'd0);
            #1;
            vec_cnt++; if (o_req_valid !== 1'b1) begin err_cnt++; $display("FAIL vs_valid[%0d] got %b exp 1", v, o_req_valid); end
            vec_cnt++; if (o_req_addr !== addr[v]) begin err_cnt++; $display("FAIL vs_addr[%0d] got %h exp %h", v, o_req_addr, addr[v]); end
            vec_cnt++; if (o_req_wdata !== 32'(eiid[v])) begin err_cnt++; $display("FAIL vs_wdata[%0d] got %h exp %h", v, o_req_wdata, 32'(eiid[v])); end
            i_req_ready = 1'b1;
            tick();
            i_req_ready = 1'b0;
            #1;
            vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL vs_idle[%0d] got %b exp 0", v, o_busy); end
        end
    endtask

    task automatic test_retry();
        tick();
        set_ch(0, 1'b1, 2'd1, 2'd1, 11'd3);
        tick();
        set_ch(0, 1'b0, 2'd0, 2'd0, 11'd0);
        #1;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (o_req_valid !== 1'b1) begin err_cnt++; $display("FAIL retry_valid[%0d] got %b exp 1", i, o_req_valid); end
            vec_cnt++; if (o_req_addr !== 32'h2800_2000 || o_req_wdata !== 32'd3) begin err_cnt++; $display("FAIL retry_payload[%0d] got %h/%h exp 28002000/3", i, o_req_addr, o_req_wdata); end
            i_req_ready = 1'b1;
            i_req_error = (i < 2);
            tick();
            i_req_ready = 1'b0;
            i_req_error = 1'b0;
            #1;
            vec_cnt++; if (o_req_valid !== 1'b0) begin err_cnt++; $display("FAIL retry_gap[%0d] got %b exp 0", i, o_req_valid); end
            vec_cnt++; if (o_drop !== 1'b0) begin err_cnt++; $display("FAIL retry_drop[%0d] got %b exp 0", i, o_drop); end
            if (i < 2) tick();
        end
        vec_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL retry_busy got %b exp 0", o_busy); end
        vec_cnt++; if (o_drop_cnt !== 16'(exp_cnt)) begin err_cnt++; $display("FAIL retry_drop_cnt got %0d exp %0d", o_drop_cnt, exp_cnt); end
    endtask

    task automatic test_exhaust(input logic with_chan_drop);
        tick();
        set_ch(1, 1'b1, 2'd0, 2'd0, 11'd12);
        tick();
        set_ch(1, 1'b0, 2'd0, 2'd0, 11'd0);
        #1;
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if (o_req_valid !== 1'b1 || o_req_wdata !== 32'd12) begin err_cnt++; $display("FAIL exhaust_issue[%0d] got %b/%h exp 1/c", i, o_req_valid, o_req_wdata); end
            i_req_ready = 1'b1;
            i_req_error = 1'b1;
            if (i == 3 && with_chan_drop) begin
                set_ch(2, 1'b1, 2'd0, 2'd0, 11'd0);
                #1;
                vec_cnt++; if (o_ch_ready !== 4'b0100) begin err_cnt++; $display("FAIL dual_ready got %b exp 0100", o_ch_ready); end
            end
            tick();
            i_req_ready = 1'b0;
            i_req_error = 1'b0;
            set_ch(2, 1'b0, 2'd0, 2'd0, 11'd0);
            #1;
            if (i < 3) begin
                vec_cnt++; if (o_drop !== 1'b0) begin err_cnt++; $display("FAIL exhaust_early_drop[%0d] got %b exp 0", i, o_drop); end
                tick();
            end
        end
        exp_cnt += with_chan_drop ? 2 : 1;
        vec_cnt++; if (o_drop !== 1'b1) begin err_cnt++; $display("FAIL exhaust_drop got %b exp 1", o_drop); end
        vec_cnt++; if (o_drop_cnt !== 16'(exp_cnt)) begin err_cnt++; $display("FAIL exhaust_drop_cnt got %0d exp %0d", o_drop_cnt, exp_cnt); end
        vec_cnt++; if (o_req_valid !== 1'b0 || o_busy !== 1'b0) begin err_cnt++; $display("FAIL exhaust_idle got %b/%b exp 0/0", o_req_valid, o_busy); end
        tick();
        vec_cnt++; if (o_drop !== 1'b0) begin err_cnt++; $display("FAIL exhaust_pulse got %b exp 0", o_drop); end
    endtask

    task automatic test_chan_drop();
        int          ch[3]   = '{1, 2, 3};
        logic [1:0]  hart[3] = '{2'd0, 2'd0, 2'd3};
        logic [1:0]  file[3] = '{2'd0, 2'd3, 2'd0};
        logic [10:0] eiid[3] = '{11'd0, 11'd4, 11'd4};
        for (int v = 0; v < 3; v++) begin
            tick();
            set_ch(ch[v], 1'b1, hart[v], file[v], eiid[v]);
            #1;
            vec_cnt++; if (o_ch_ready !== 4'(1 << ch[v])) begin err_cnt++; $display("FAIL cdrop_ready[%0d] got %b exp %b", v, o_ch_ready, 4'(1 << ch[v])); end
            tick();
            set_ch(ch[v], 1'b0, 2'd0, 2'd0, 11'd0);
            exp_cnt++;
            #1;
            vec_cnt++; if (o_drop !== 1'b1) begin err_cnt++; $display("FAIL cdrop_pulse[%0d] got %b exp 1", v, o_drop); end
            vec_cnt++; if (o_drop_cnt !== 16'(exp_cnt)) begin err_cnt++; $display("FAIL cdrop_cnt[%0d] got %0d exp %0d", v, o_drop_cnt, exp_cnt); end
            vec_cnt++; if (o_req_valid !== 1'b0 || o_busy !== 1'b0) begin err_cnt++; $display("FAIL cdrop_not_queued[%0d] got %b/%b exp 0/0", v, o_req_valid, o_busy); end
            tick();
            vec_cnt++; if (o_drop !== 1'b0) begin err_cnt++; $display("FAIL cdrop_clear[%0d] got %b exp 0", v, o_drop); end
        end
    endtask

    task automatic test_fairness();
        logic [31:0] drain[3] = '{32'd3, 32'd4, 32'd1};
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 2'd0, 2'd0, 11'(c + 1));
        #1;
        for (int c = 0; c < 4; c++) begin
            vec_cnt++; if (o_ch_ready !== 4'(1 << c)) begin err_cnt++; $display("FAIL rr_grant[%0d] got %b exp %b", c, o_ch_ready, 4'(1 << c)); end
            tick();
        end
        vec_cnt++; if (o_ch_ready !== 4'b0000) begin err_cnt++; $display("FAIL rr_full got %b exp 0000", o_ch_ready); end
        vec_cnt++; if (o_req_valid !== 1'b1 || o_req_wdata !== 32'd1) begin err_cnt++; $display("FAIL rr_head got %b/%h exp 1/1", o_req_valid, o_req_wdata); end
        i_req_ready = 1'b1;
        tick();
        vec_cnt++; if (o_ch_ready !== 4'b0001) begin err_cnt++; $display("FAIL rr_after_pop got %b exp 0001", o_ch_ready); end
        vec_cnt++; if (o_req_wdata !== 32'd2) begin err_cnt++; $display("FAIL rr_second got %h exp 2", o_req_wdata); end
        tick();
        i_ch_valid = '0;
        for (int k = 0; k < 3; k++) begin
            vec_cnt++; if (o_req_valid !== 1'b1 || o_req_wdata !== drain[k]) begin err_cnt++; $display("FAIL rr_drain[%0d] got %b/%h exp 1/%h", k, o_req_valid, o_req_wdata, drain[k]); end
            tick();
        end
        i_req_ready = 1'b0;
        vec_cnt++; if (o_req_valid !== 1'b0 || o_busy !== 1'b0) begin err_cnt++; $display("FAIL rr_empty got %b/%b exp 0/0", o_req_valid, o_busy); end
    endtask

    task automatic test_reset_mid();
        i_req_ready = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 2'd0, 2'd0, 11'(20 + c));
        tick();
        tick();
        tick();
        i_ch_valid = '0;
        #1;
        vec_cnt++; if (o_req_valid !== 1'b1 || o_busy !== 1'b1) begin err_cnt++; $display("FAIL rmid_issue got %b/%b exp 1/1", o_req_valid, o_busy); end
        set_ch(0, 1'b1, 2'd0, 2'd0, 11'd30);
        i_rst = 1'b1;
        #1;
        vec_cnt++; if (o_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got %b exp 0", o_req_valid); end
        vec_cnt++; if (o_req_addr !== 32'd0 || o_req_wdata !== 32'd0) begin err_cnt++; $display("FAIL rmid_payload got %h/%h exp 0/0", o_req_addr, o_req_wdata); end
        vec_cnt++; if (o_busy !== 1'b0 || o_ch_ready !== 4'b0000) begin err_cnt++; $display("FAIL rmid_quiet got %b/%b exp 0/0000", o_busy, o_ch_ready); end
        tick();
        i_rst = 1'b0;
        i_ch_valid = '0;
        i_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            vec_cnt++; if (o_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_no_write[%0d] got %b exp 0", k, o_req_valid); end
        end
        i_req_ready = 1'b0;
        vec_cnt++; if (o_drop_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_drop_cnt got %0d exp 0", o_drop_cnt); end
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_vs_targets();
        test_retry();
        test_exhaust(1'b0);
        test_exhaust(1'b1);
        test_chan_drop();
        test_fairness();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/aplic_msi_dispatcher.md
APLIC_MSI_DISPATCHER -- requirements
Module: aplic_msi_dispatcher

Interface
REQ-001 Parameter NR_CH, default 4: number of MSI request channels (1..16).
REQ-002 Parameter FIFO_DEPTH, default 4: message buffer entries, power of two, at least 2.
REQ-003 Parameter NR_HARTS, default 1: number of target harts (1..64).
REQ-004 Parameter NR_VS_FILES, default 1: guest interrupt files per hart; file index 0=M, 1=S, 2..NR_VS_FILES+1=VS.
REQ-005 Parameter EIID_W, default 11: interrupt identity width.
REQ-006 Parameter MAX_RETRY, default 3: maximum re-issues after an errored write.
REQ-007 Parameter BASE_M, default 32'h2400_0000: M-level IMSIC base address.
REQ-008 Parameter BASE_S, default 32'h2800_0000: S/VS-level IMSIC base address.
REQ-009 Port i_clk, input, 1: the single clock.
REQ-010 Port i_rst, input, 1: reset, asynchronous and active-high.
REQ-011 Port i_ch_valid, input, NR_CH: per-channel request valid.
REQ-012 Port o_ch_ready, output, NR_CH: per-channel accept; at most one bit set per cycle.
REQ-013 Port i_ch_hart, input, NR_CH x clog2(NR_HARTS) (minimum 1 bit): target hart index.
REQ-014 Port i_ch_file, input, NR_CH x clog2(NR_VS_FILES+2): target interrupt-file index.
REQ-015 Port i_ch_eiid, input, NR_CH x EIID_W: interrupt identity.
REQ-016 Ports o_req_addr (32), o_req_wdata (32), o_req_valid (1), output: single-beat write request to the IMSIC bus.
REQ-017 Ports i_req_ready (1), i_req_error (1), input: write completion; i_req_error is valid only when i_req_ready is high.
REQ-018 Ports o_drop (1), o_drop_cnt (16), o_busy (1), output: discard pulse, saturating discard count, and activity flag.

Function
REQ-019 The arbiter SHALL be round-robin; the pointer advances to the granted channel plus 1 on each acceptance.
REQ-020 Accept: o_ch_ready[g] = grant[g] and not FIFO full; full is registered, so a push is never accepted on a full cycle even if a pop occurs.
REQ-021 An accepted request with eiid==0 or file > NR_VS_FILES+1 or hart >= NR_HARTS SHALL NOT be enqueued; it SHALL set o_drop for one cycle and increment o_drop_cnt.
REQ-022 Address SHALL be computed at enqueue.
- File 0: BASE_M + hart*4096.
- Otherwise: BASE_S + (hart*(NR_VS_FILES+1) + file-1)*4096.
- Arithmetic is 32-bit, wrapping.
REQ-023 o_req_wdata SHALL be the eiid zero-extended to 32 bits.
REQ-024 The master FSM states SHALL be IDLE, ISSUE, BACKOFF.
REQ-025 IDLE goes to ISSUE when the FIFO is non-empty; the earliest o_req_valid is 1 cycle after acceptance.
REQ-026 In ISSUE, o_req_valid=1 and addr/wdata SHALL be held stable until i_req_ready.
REQ-027 On ISSUE with ready and no error: pop, clear the retry count, then go to ISSUE if the FIFO is still non-empty, else IDLE.
REQ-028 On ISSUE with ready and error, when retry < MAX_RETRY: increment retry and go to BACKOFF for exactly 1 cycle (o_req_valid=0), then ISSUE with the same entry.
REQ-029 On ISSUE with ready and error, when retry == MAX_RETRY: pop, pulse o_drop, increment o_drop_cnt, clear retry.
REQ-030 If a channel drop (REQ-021) and a bus drop (REQ-029) occur in the same cycle, o_drop_cnt SHALL increase by 2; it saturates at 16'hFFFF.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a push and a pop in the same non-full cycle keep the occupancy unchanged.
REQ-032 o_busy = FIFO non-empty or FSM not in IDLE.

Reset
REQ-033 On i_rst assertion, immediately and asynchronously:
- o_req_valid, o_ch_ready, o_drop and o_busy go to 0;
- o_drop_cnt, retry, FIFO pointers and the arbiter pointer go to 0;
- the FSM goes to IDLE.
REQ-034 Reset mid-transaction SHALL discard all buffered messages without a drop count; address/wdata outputs are 0 during reset.

Structure
REQ-035 The FSM state enum, the 4096 file stride constant and the default base addresses SHALL live in a shared aia package.
REQ-036 The FIFO SHALL be a separate sub-module, aplic_msi_fifo.

Verification
REQ-037 Single message: ch0 sends hart 0, file 0, eiid 5 -> one write to 0x2400_0000 with wdata 5, issued 1 cycle after acceptance.
REQ-038 VS target: with NR_VS_FILES=1, hart 1, file 2, eiid 7 -> write to 0x2800_0000 + 3*4096 = 0x2800_3000.
REQ-039 Fairness: all 4 channels valid continuously -> grants are ch0, ch1, ch2, ch3, ch0...; the FIFO fills at 4 and ready drops until the first pop.
REQ-040 Retry: i_req_error on the first 2 completions -> 3 issues of the same addr/data, each separated by a 1-cycle gap; o_drop stays 0.
REQ-041 Exhausted retries: error on 4 consecutive completions (MAX_RETRY=3) -> the entry is popped, o_drop pulses once, and o_drop_cnt=1.
REQ-042 Reset in ISSUE with 3 messages buffered -> o_req_valid goes low in the same cycle; after release, no write is issued and o_drop_cnt=0.
